baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Parametrised successor to the fixed-divisor baud tick generator. Produces an oversample tick whose period the host can set at run time, with a fractional divisor so that non-integer clock/baud ratios average out exactly. Also produces per-bit and mid-bit strobes, and accepts a phase resync so the UART receiver can align sampling to a start-bit edge. Sits between the register/config interface and the UART TX/RX engines; one instance per UART channel.

## Interface
- `CLK_SPEED`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: reset-time baud rate.
- `OVERSAMPLE`, default 16: ticks per bit. Must be an even number ≥ 4.
- `INT_W`, default 16: width of the integer divisor part.
- `FRAC_W`, default 4: width of the fractional divisor part.
- `DIV_RESET`, default `CLK_SPEED*2**FRAC_W/(OVERSAMPLE*BAUD_RATE)` (truncated): reset divisor in fixed-point INT.FRAC form. 651.0 = 0x28B0 for the defaults.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable. Low freezes all counters.
- `resync`  in  1  single-cycle pulse that restarts tick and bit phase.
- `div_wr`  in  1  single-cycle pulse that loads `div_in` as the pending divisor.
- `div_in`  in  INT_W+FRAC_W  new divisor; upper INT_W bits are the integer part, lower FRAC_W bits the fraction.
- `tick`  out  1  oversample strobe, one cycle wide.
- `mid_tick`  out  1  strobe on the tick at the middle of a bit.
- `bit_tick`  out  1  strobe on the tick that ends a bit.
- `div_cur`  out  INT_W+FRAC_W  divisor currently in use.

## Operation
- State:
  - `cnt` (INT_W+1 bits), reset value 1.
  - `acc` (FRAC_W bits), reset value 0.
  - `os_cnt` (0..OVERSAMPLE-1), reset value 0.
  - `period`, reset value int(DIV_RESET).
  - `div_cur`, reset value DIV_RESET.
  - `pend_valid`, reset value 0.
- Outputs: every output is registered. `tick`, `mid_tick` and `bit_tick` reset to 0.
- Counting, per clock edge when `en` = 1 and `resync` = 0:
  - If `cnt` < `period`: `cnt` increments and `tick` is 0.
  - Otherwise, a tick event occurs: `tick` goes to 1 and `cnt` goes to 1.
- Fraction handling at each tick event:
  - `{carry, acc} <= acc + frac(div_cur)`.
  - The next `period` is `int(div_cur) + carry`.
  - The first period after reset or resync is `int(div_cur)`.
- Bit strobes at each tick event:
  - `os_cnt` wraps modulo OVERSAMPLE.
  - `mid_tick` = 1 when `os_cnt` was OVERSAMPLE/2-1 before the increment.
  - `bit_tick` = 1 when `os_cnt` was OVERSAMPLE-1 before the increment.
- Integer part 0 is treated as 1, so `tick` can be asserted every cycle. The fraction is ignored when the integer part is 0.
- Divisor update:
  - `div_wr` captures `div_in` into a pending register and sets `pend_valid`.
  - The pending value is applied (copied to `div_cur`, `period` and `acc` recomputed, `acc` cleared) on the next tick event, so the current period is never truncated.
  - A later `div_wr` before application overwrites the pending value.
  - If `en` = 0, the pending value is applied on the next edge.
- `en` = 0: `cnt`, `acc` and `os_cnt` hold; all strobes are 0.
- `resync` takes priority over `en` and over a tick event:
  - `cnt` goes to 1, `acc` to 0 and `os_cnt` to 0; strobes are 0 on the next cycle.
  - A pending divisor is applied in the same edge.
  - If `div_wr` and `resync` occur in the same cycle, `div_in` is applied immediately.
- Reset mid-operation: all state returns to its reset values asynchronously. Any pending divisor is discarded.

## Timing
- Strobe spacing with integer divisor N: one `tick` every N cycles. After `rst_n` is released, the first `tick` is high in the cycle following the N-th rising edge.
- `mid_tick` and `bit_tick` are only ever high together with `tick`, never on their own.
- `bit_tick` period is OVERSAMPLE × N cycles. `mid_tick` leads `bit_tick` by (OVERSAMPLE/2) ticks.
- Resync latency: after `resync` is sampled at edge E, the first `tick` comes at edge E+N. The first `mid_tick` comes on the (OVERSAMPLE/2)-th tick.
- `div_cur` changes on the same edge that applies the divisor. The new spacing starts with the interval that follows that tick.

## Test plan
- Defaults (N = 651): after reset, `tick` pulses every 651 cycles; `bit_tick` every 10416 cycles; `mid_tick` 5208 cycles before each `bit_tick`.
- `div_in` = 0x0048 (4.5) with FRAC_W = 4:
  - Tick intervals are 4, 4, 5, 4, 5, ….
  - Across any 32 consecutive ticks, the sum of intervals is 144 ± 1.
- `div_wr` mid-period:
  - The current interval completes at the old N.
  - `div_cur` updates on that tick.
  - The following interval equals the new N.
  - A second `div_wr` before the next tick causes only the last value to be applied.
- `resync` at an arbitrary cycle:
  - Strobes are 0 on the next cycle.
  - `tick` arrives N edges later.
  - `mid_tick` falls on the 8th tick and `bit_tick` on the 16th tick.
- `en` low for 100 cycles mid-period: there are no strobes during the gap, and the interval resumes with the remaining count.
- `div_in` = 0 and 0x0010 (1.0): `tick` is high every cycle. Then assert `rst_n` low mid-count: all outputs are 0 immediately and `div_cur` = DIV_RESET.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-divisor oversample tick generator with mid-bit / end-of-bit strobes.
// Divisor is INT.FRAC fixed point; a fraction accumulator stretches periods by one cycle on carry.
module baud_gen_frac #(
  parameter int CLK_SPEED  = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter logic [INT_W+FRAC_W-1:0] DIV_RESET =
    (INT_W+FRAC_W)'((64'(CLK_SPEED) << FRAC_W) / (64'(OVERSAMPLE) * 64'(BAUD_RATE)))
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    resync,
  input  logic                    div_wr,
  input  logic [INT_W+FRAC_W-1:0] div_in,
  output logic                    tick,
  output logic                    mid_tick,
  output logic                    bit_tick,
  output logic [INT_W+FRAC_W-1:0] div_cur
);
  localparam int DIV_W = INT_W + FRAC_W;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef logic [INT_W:0] per_t;

  // Integer part 0 behaves as 1 so the block can tick every cycle.
  function automatic per_t int_of(input logic [DIV_W-1:0] d);
    logic [INT_W-1:0] i;
    i = d[DIV_W-1:FRAC_W];
    return (i == '0) ? per_t'(1) : {1'b0, i};
  endfunction

  function automatic logic [FRAC_W-1:0] frac_of(input logic [DIV_W-1:0] d);
    return (d[DIV_W-1:FRAC_W] == '0) ? '0 : d[FRAC_W-1:0];
  endfunction

  per_t              cnt, period;
  logic [FRAC_W-1:0] acc;
  logic [OS_W-1:0]   os_cnt;
  logic [DIV_W-1:0]  pend;
  logic              pend_valid;

  logic              tick_ev;
  logic              apply;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  new_div;

  assign tick_ev = en && !resync && (cnt >= period);
  assign acc_sum = {1'b0, acc} + {1'b0, frac_of(div_cur)};
  // A write coinciding with resync bypasses the pending register.
  assign new_div = (resync && div_wr) ? div_in : pend;
  assign apply   = (resync && (div_wr || pend_valid)) ||
                   (pend_valid && (tick_ev || !en));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= per_t'(1);
      acc        <= '0;
      os_cnt     <= '0;
      period     <= int_of(DIV_RESET);
      div_cur    <= DIV_RESET;
      pend       <= '0;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      mid_tick   <= 1'b0;
      bit_tick   <= 1'b0;
    end else begin
      tick     <= tick_ev;
      mid_tick <= tick_ev && (os_cnt == OS_MID);
      bit_tick <= tick_ev && (os_cnt == OS_LAST);

      if (div_wr) pend <= div_in;
      if (apply)       pend_valid <= div_wr && !resync;
      else if (div_wr) pend_valid <= 1'b1;

      if (resync) begin
        cnt    <= per_t'(1);
        acc    <= '0;
        os_cnt <= '0;
      end else if (tick_ev) begin
        cnt    <= per_t'(1);
        acc    <= acc_sum[FRAC_W-1:0];
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end else if (en) begin
        cnt    <= cnt + per_t'(1);
      end

      // Applying a new divisor restarts the fraction sequence cleanly.
      if (apply) begin
        div_cur <= new_div;
        period  <= int_of(new_div);
        acc     <= '0;
      end else if (resync) begin
        period  <= int_of(div_cur);
      end else if (tick_ev) begin
        period  <= int_of(div_cur) + per_t'(acc_sum[FRAC_W]);
      end
    end
  end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench: expected strobe edges are queued ahead of time and
// popped by a monitor whenever any strobe is seen.
module tb_baud_gen_frac;
  localparam int OS    = 16;
  localparam int DIV_W = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             resync = 1'b0;
  logic             div_wr = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             tick, mid_tick, bit_tick;
  logic [DIV_W-1:0] div_cur;

  baud_gen_frac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .resync   (resync),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .tick     (tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .div_cur  (div_cur)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic mid;
    logic bt;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   last_tick = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int idx);
    exp_t e;
    e.cyc = c;
    e.mid = ((idx % OS) == OS/2);
    e.bt  = ((idx % OS) == 0);
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (tick || mid_tick || bit_tick)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_cycle", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick",       longint'(tick), 1);
        chk("mid_tick",   longint'(mid_tick), longint'(e.mid));
        chk("bit_tick",   longint'(bit_tick), longint'(e.bt));
        last_tick = cyc;
      end
    end
  end

  // Advance to just after the next falling edge, after the monitor has run.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Resync pulse (optionally with a divisor write); returns the sampling edge.
  task automatic do_resync(input logic wr, input logic [DIV_W-1:0] v,
                           input logic [DIV_W-1:0] exp_div, output int e);
    resync = 1'b1;
    div_wr = wr;
    div_in = v;
    e = cyc + 1;
    step();
    resync = 1'b0;
    div_wr = 1'b0;
    chk("resync_quiet_tick", longint'(tick), 0);
    chk("resync_div_cur", longint'(div_cur), longint'(exp_div));
  endtask

  initial begin
    int e, t, c0, sum;

    // Reset state and default divisor 651.0
    step();
    chk("rst_tick", longint'(tick), 0);
    chk("rst_mid", longint'(mid_tick), 0);
    chk("rst_bit", longint'(bit_tick), 0);
    chk("rst_div_cur", longint'(div_cur), 20'h028B0);
    rst_n = 1'b1;
    en    = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 17; i++) push(c0 + 651*i, i);
    drain(12000);

    // Fractional divisor 4.5: intervals 4,4,5,4,5,...
    do_resync(1'b1, 20'h00048, 20'h00048, e);
    t = e;
    for (int i = 1; i <= 32; i++) begin
      t += (i == 1) ? 4 : ((i % 2 == 0) ? 4 : 5);
      push(t, i);
    end
    drain(400);
    sum = last_tick - e;
    chk("frac_sum_32", longint'(sum >= 143 && sum <= 145), 1);

    // Two divisor writes mid-period: old interval completes, last write wins
    do_resync(1'b1, 20'h00070, 20'h00070, e);
    push(e + 7, 1);
    push(e + 14, 2);
    push(e + 21, 3);
    push(e + 33, 4);
    push(e + 45, 5);
    to_cyc(e + 16);
    div_wr = 1'b1; div_in = 20'h000A0;
    step();
    div_wr = 1'b0;
    to_cyc(e + 18);
    div_wr = 1'b1; div_in = 20'h000C0;
    step();
    div_wr = 1'b0;
    to_cyc(e + 20);
    chk("div_cur_before_apply", longint'(div_cur), 20'h00070);
    step();
    chk("div_cur_after_apply", longint'(div_cur), 20'h000C0);
    drain(400);

    // Bare resync at an arbitrary offset, N = 12
    to_cyc(cyc + int'($urandom_range(1, 10)));
    do_resync(1'b0, 20'h0, 20'h000C0, e);
    for (int i = 1; i <= 16; i++) push(e + 12*i, i);
    drain(400);

    // Enable low for 100 cycles mid-period
    t = cyc;
    push(t + 112, 17);
    push(t + 124, 18);
    to_cyc(t + 5);
    en = 1'b0;
    to_cyc(t + 55);
    chk("en_gap_tick", longint'(tick), 0);
    to_cyc(t + 105);
    en = 1'b1;
    drain(400);

    // Integer part 0, then 1.0: tick every cycle
    do_resync(1'b1, 20'h00000, 20'h00000, e);
    for (int i = 1; i <= 20; i++) push(e + i, i);
    drain(100);
    do_resync(1'b1, 20'h00010, 20'h00010, e);
    for (int i = 1; i <= 16; i++) push(e + i, i);
    drain(100);

    // Asynchronous reset mid-count
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", longint'(tick), 0);
    chk("async_rst_bit", longint'(bit_tick), 0);
    chk("async_rst_mid", longint'(mid_tick), 0);
    chk("async_rst_div_cur", longint'(div_cur), 20'h028B0);
    step();
    rst_n = 1'b1;
    c0 = cyc;
    push(c0 + 651, 1);
    drain(1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
